// File: rtl/dep_track_table_pkg.sv
// Shared constants for the dependency tracking table.
// Default geometry and the index/count widths derived from it.
package dep_track_table_pkg;

  localparam int REGNUM_D = 32;
  localparam int BS_D     = 16;
  localparam int RIW_D    = $clog2(REGNUM_D);
  localparam int CIW_D    = $clog2(BS_D);
  localparam int CNTW_D   = $clog2(BS_D + 1);

endpackage

// File: rtl/dep_track_table_if.sv
// Insert/retire request bundle and dependency result bundle.
// The master drives requests; the table is the slave.
interface dep_track_table_if
  import dep_track_table_pkg::*;
#(
  parameter int REGNUM = REGNUM_D,
  parameter int BS     = BS_D
) ();

  localparam int RIW  = $clog2(REGNUM);
  localparam int CIW  = $clog2(BS);
  localparam int CNTW = $clog2(BS + 1);

  logic            ins_valid;
  logic [CIW-1:0]  ins_col;
  logic [RIW-1:0]  rs1;
  logic [RIW-1:0]  rs2;
  logic [RIW-1:0]  rd;
  logic            rs1_en;
  logic            rs2_en;
  logic            rd_en;
  logic            ret_valid;
  logic [CIW-1:0]  ret_col;
  logic [BS-1:0]   idt;
  logic            idt_valid;
  logic            ovw;
  logic [CNTW-1:0] occ;
  logic            full;
  logic            empty;

  modport master (
    output ins_valid, ins_col,
    output rs1, rs2, rd,
    output rs1_en, rs2_en, rd_en,
    output ret_valid, ret_col,
    input  idt, idt_valid, ovw,
    input  occ, full, empty
  );

  modport slave (
    input  ins_valid, ins_col,
    input  rs1, rs2, rd,
    input  rs1_en, rs2_en, rd_en,
    input  ret_valid, ret_col,
    output idt, idt_valid, ovw,
    output occ, full, empty
  );

endinterface

// File: rtl/dep_track_col_mask.sv
// One-hot column mask; out-of-range columns give an all-zero mask.
// Used for insert clear, retire clear and self-bit removal.
module dep_track_col_mask #(
  parameter int BS = 16,
  parameter int CW = 4
) (
  input  logic [CW-1:0] col_i,
  input  logic          en_i,
  output logic [BS-1:0] mask_o
);

  always_comb begin
    mask_o = '0;
    for (int i = 0; i < BS; i++) begin
      mask_o[i] = en_i && (col_i == CW'(i));
    end
  end

endmodule

// File: rtl/dep_track_table.sv
// RS/RD dependency matrices over the instruction-buffer columns.
// Produces the registered dependency vector of each inserted op.
module dep_track_table
  import dep_track_table_pkg::*;
#(
  parameter int REGNUM   = REGNUM_D,
  parameter int BS       = BS_D,
  parameter bit ZERO_REG = 1'b1
) (
  input logic clk,
  input logic rst_n,
  dep_track_table_if.slave bus
);

  localparam int RIW  = $clog2(REGNUM);
  localparam int CIW  = $clog2(BS);
  localparam int CNTW = $clog2(BS + 1);

  logic [BS-1:0]   rs_q [REGNUM];
  logic [BS-1:0]   rd_q [REGNUM];
  logic [BS-1:0]   rs_d [REGNUM];
  logic [BS-1:0]   rd_d [REGNUM];
  logic [BS-1:0]   cv_q, cv_d;
  logic [BS-1:0]   idt_q, idt_d;
  logic            idt_valid_q;
  logic            ovw_q, ovw_d;
  logic [CNTW-1:0] occ_q, occ_d;
  logic [BS-1:0]   ins_m, ret_m, clr, dep;
  logic            ins_acc;
  logic            e1, e2, ed;

  dep_track_col_mask #(.BS(BS), .CW(CIW)) u_ins_mask (
    .col_i  (bus.ins_col),
    .en_i   (bus.ins_valid),
    .mask_o (ins_m)
  );

  dep_track_col_mask #(.BS(BS), .CW(CIW)) u_ret_mask (
    .col_i  (bus.ret_col),
    .en_i   (bus.ret_valid),
    .mask_o (ret_m)
  );

  function automatic logic op_ok(
    input logic [RIW-1:0] idx,
    input logic           en
  );
    return en
        && (int'(idx) < REGNUM)
        && !(ZERO_REG && (idx == '0));
  endfunction

  assign e1      = op_ok(bus.rs1, bus.rs1_en);
  assign e2      = op_ok(bus.rs2, bus.rs2_en);
  assign ed      = op_ok(bus.rd, bus.rd_en);
  assign ins_acc = |ins_m;
  assign clr     = ins_m | ret_m;

  always_comb begin
    dep = '0;
    for (int r = 0; r < REGNUM; r++) begin
      rs_d[r] = rs_q[r] & ~clr;
      rd_d[r] = rd_q[r] & ~clr;
      if (e1 && (bus.rs1 == RIW'(r))) begin
        rs_d[r] = rs_d[r] | ins_m;
        dep     = dep | rd_q[r];
      end
      if (e2 && (bus.rs2 == RIW'(r))) begin
        rs_d[r] = rs_d[r] | ins_m;
        dep     = dep | rd_q[r];
      end
      if (ed && (bus.rd == RIW'(r))) begin
        rd_d[r] = rd_d[r] | ins_m;
        dep     = dep | rs_q[r] | rd_q[r];
      end
    end
  end

  // A same-column retire frees the slot, so that insert is no overwrite.
  assign cv_d  = (cv_q & ~clr) | ins_m;
  assign idt_d = dep & cv_q & ~ins_m & ~ret_m;
  assign ovw_d = |(ins_m & cv_q & ~ret_m);

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < BS; i++) begin
      occ_d = occ_d + CNTW'(cv_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REGNUM; r++) begin
        rs_q[r] <= '0;
        rd_q[r] <= '0;
      end
      cv_q        <= '0;
      idt_q       <= '0;
      idt_valid_q <= 1'b0;
      ovw_q       <= 1'b0;
      occ_q       <= '0;
    end else begin
      for (int r = 0; r < REGNUM; r++) begin
        rs_q[r] <= rs_d[r];
        rd_q[r] <= rd_d[r];
      end
      cv_q        <= cv_d;
      idt_valid_q <= ins_acc;
      ovw_q       <= ovw_d;
      occ_q       <= occ_d;
      if (ins_acc) begin
        idt_q <= idt_d;
      end
    end
  end

  assign bus.idt       = idt_q;
  assign bus.idt_valid = idt_valid_q;
  assign bus.ovw       = ovw_q;
  assign bus.occ       = occ_q;
  assign bus.full      = (occ_q == CNTW'(BS));
  assign bus.empty     = (occ_q == '0);

endmodule

// File: tb/tb_dep_track_table.sv
// Directed bench for dep_track_table with hand-computed expectations.
// Inputs change on the falling edge; outputs sampled 1ns after rising.
module tb_dep_track_table;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  dep_track_table_if #(.REGNUM(32), .BS(16)) bus ();

  dep_track_table #(.REGNUM(32), .BS(16), .ZERO_REG(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.ins_valid = 1'b0;
    bus.ret_valid = 1'b0;
    bus.rs1_en = 1'b0;
    bus.rs2_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  // One clock: optional insert and optional retire.
  task automatic step(input logic iv, input int col,
                      input int r1, input logic e1,
                      input int r2, input logic e2,
                      input int d, input logic ed,
                      input logic rv, input int rcol);
    @(negedge clk);
    bus.ins_valid = iv;
    bus.ins_col = 4'(col);
    bus.rs1 = 5'(r1);
    bus.rs1_en = e1;
    bus.rs2 = 5'(r2);
    bus.rs2_en = e2;
    bus.rd = 5'(d);
    bus.rd_en = ed;
    bus.ret_valid = rv;
    bus.ret_col = 4'(rcol);
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    idle_in();
    bus.ins_col = '0;
    bus.ret_col = '0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    bus.rd = '0;
    #12;
    chk("rst_idt", 32'(bus.idt), 0);
    chk("rst_idtv", 32'(bus.idt_valid), 0);
    chk("rst_ovw", 32'(bus.ovw), 0);
    chk("rst_occ", 32'(bus.occ), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // RAW
    step(1, 0, 0, 0, 0, 0, 5, 1, 0, 0);
    chk("raw0_idt", 32'(bus.idt), 0);
    chk("raw0_v", 32'(bus.idt_valid), 1);
    chk("raw0_occ", 32'(bus.occ), 1);
    step(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    chk("raw1_idt", 32'(bus.idt), 32'h1);
    chk("raw1_v", 32'(bus.idt_valid), 1);
    chk("raw1_occ", 32'(bus.occ), 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("hold_v", 32'(bus.idt_valid), 0);
    chk("hold_idt", 32'(bus.idt), 32'h1);

    // WAR, then WAW with same-cycle retire
    do_reset();
    step(1, 0, 3, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 3, 1, 0, 0);
    chk("war_idt", 32'(bus.idt), 32'h1);
    step(1, 2, 0, 0, 0, 0, 3, 1, 1, 0);
    chk("waw_idt", 32'(bus.idt), 32'h2);
    chk("waw_occ", 32'(bus.occ), 2);
    chk("waw_ovw", 32'(bus.ovw), 0);

    // Register zero
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("z0_occ", 32'(bus.occ), 1);
    step(1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    chk("z1_idt", 32'(bus.idt), 0);
    step(1, 2, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("z2_idt", 32'(bus.idt), 0);

    // Fill, overwrite, insert+retire same column
    do_reset();
    for (int c = 0; c < 15; c++) begin
      step(1, c, 0, 0, 0, 0, c + 1, 1, 0, 0);
    end
    chk("f15_occ", 32'(bus.occ), 15);
    chk("f15_full", 32'(bus.full), 0);
    step(1, 15, 0, 0, 0, 0, 16, 1, 0, 0);
    chk("f16_occ", 32'(bus.occ), 16);
    chk("f16_full", 32'(bus.full), 1);
    chk("f16_empty", 32'(bus.empty), 0);
    chk("f16_ovw", 32'(bus.ovw), 0);
    step(1, 4, 1, 1, 0, 0, 20, 1, 0, 0);
    chk("ow_ovw", 32'(bus.ovw), 1);
    chk("ow_occ", 32'(bus.occ), 16);
    chk("ow_idt", 32'(bus.idt), 32'h1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ow_pulse", 32'(bus.ovw), 0);
    step(1, 4, 2, 1, 0, 0, 0, 0, 1, 4);
    chk("ir_ovw", 32'(bus.ovw), 0);
    chk("ir_occ", 32'(bus.occ), 16);
    chk("ir_idt", 32'(bus.idt), 32'h2);
    chk("ir_v", 32'(bus.idt_valid), 1);

    // Empty retire, async reset mid-operation
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    chk("er_occ", 32'(bus.occ), 0);
    chk("er_empty", 32'(bus.empty), 1);
    for (int c = 0; c < 6; c++) begin
      step(1, c, 0, 0, 0, 0, c + 1, 1, 0, 0);
    end
    step(1, 6, 6, 1, 0, 0, 7, 1, 0, 0);
    chk("m7_occ", 32'(bus.occ), 7);
    chk("m7_idt", 32'(bus.idt), 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_occ", 32'(bus.occ), 0);
    chk("ar_idt", 32'(bus.idt), 0);
    chk("ar_empty", 32'(bus.empty), 1);
    chk("ar_v", 32'(bus.idt_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 3, 6, 1, 0, 0, 0, 0, 0, 0);
    chk("pr_idt", 32'(bus.idt), 0);
    chk("pr_v", 32'(bus.idt_valid), 1);
    chk("pr_occ", 32'(bus.occ), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dep_track_table.md
DEP_TRACK_TABLE -- requirements
Module: dep_track_table

Interface
REQ-001 Parameter REGNUM, default 32, number of architectural registers.
REQ-002 Parameter BS, default 16, instruction-buffer columns.
REQ-003 Parameter ZERO_REG, default 1; when 1, register 0 never creates or carries a dependency.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ins_valid  input  1  insert an instruction this cycle.
REQ-007 ins_col  input  clog2(BS)  buffer column of the inserted instruction.
REQ-008 rs1, rs2, rd  input  clog2(REGNUM) each  source and destination register indices.
REQ-009 rs1_en, rs2_en, rd_en  input  1 each  qualify each operand; a disabled operand is ignored.
REQ-010 ret_valid  input  1  retire (free) a column this cycle.
REQ-011 ret_col  input  clog2(BS)  column being retired.
REQ-012 idt  output  BS  registered dependency vector of the last inserted instruction.
REQ-013 idt_valid  output  1  one-cycle pulse qualifying idt.
REQ-014 ovw  output  1  one-cycle pulse: insert landed on an already-occupied column.
REQ-015 occ  output  clog2(BS+1)  number of occupied columns.
REQ-016 full, empty  output  1 each  occ==BS, occ==0.

Function
REQ-017 Two tables SHALL be kept, RS and RD, each REGNUM rows x BS columns, plus a BS-bit column-valid vector CV.
REQ-018 On insert, column ins_col of both tables SHALL be cleared, then RS[rs1] (if rs1_en), RS[rs2] (if rs2_en), RD[rd] (if rd_en) set at ins_col, and CV[ins_col] set.
REQ-019 With ZERO_REG=1, any operand index 0 SHALL be treated as disabled.
REQ-020 idt SHALL equal (RD[rs1]&rs1_en | RD[rs2]&rs2_en | RS[rd]&rd_en | RD[rd]&rd_en), using table state before the edge, ANDed with CV, with bit ins_col cleared.
REQ-021 Latency: idt and idt_valid SHALL appear on the edge that accepts the insert; idt holds its value until the next insert; idt_valid is low in cycles without an insert.
REQ-022 On retire, column ret_col of both tables and CV[ret_col] SHALL be cleared.
REQ-023 Insert and retire in the same cycle on different columns: both take effect; bit ret_col SHALL be cleared in the idt produced that cycle.
REQ-024 Insert and retire on the same column: insert wins (column ends occupied with new contents); occ unchanged; ovw not asserted.
REQ-025 Insert on a column with CV set (and no same-column retire) SHALL overwrite it and pulse ovw; occ unchanged.
REQ-026 Retire of a column with CV clear SHALL be a no-op; occ never underflows.
REQ-027 occ SHALL count set bits of CV, updated on the same edge as CV; full/empty are derived combinationally from occ.
REQ-028 Out-of-range indices (>= REGNUM or >= BS for non-power-of-two parameters) SHALL be ignored for writes and read as zero.

Reset
REQ-029 While rst_n is low: RS, RD, CV cleared to 0; idt=0; idt_valid=0; ovw=0; occ=0; empty=1; full=0.
REQ-030 Reset asserted mid-operation SHALL discard all columns immediately, without waiting for a clock edge; the first edge after rst_n rises accepts an insert normally.

Structure
REQ-031 A shared package SHALL hold the default REGNUM/BS constants and the derived register-index, column-index and count widths.
REQ-032 One sub-module, dep_track_col_mask, SHALL produce the BS-bit one-hot column mask used for insert clear, retire clear and self-bit removal; it is instantiated twice (ins_col, ret_col).

Verification
REQ-033 Reset, then insert col0 rd=5; next insert col1 rs1=5 -> idt=0x0002... no: idt=0x0001, idt_valid pulse, occ=2.
REQ-034 Insert col0 rs1=3, then col1 rd=3 -> idt=0x0001 (WAR); then retire col0 and, the same cycle, insert col2 rd=3 -> idt=0x0002 (WAW on col1 only).
REQ-035 ZERO_REG=1: insert col0 rd=0, then col1 rs1=0 rs2=0 -> idt=0x0000.
REQ-036 Fill all 16 columns -> full=1, occ=16; insert col4 again -> ovw pulse, occ=16; insert+retire col4 same cycle -> ovw=0, occ=16.
REQ-037 Retire an empty column with occ=0 -> occ stays 0, empty=1; assert rst_n low between clock edges with occ=7 -> occ=0, idt=0 immediately.
